// File: rtl/rr_arbiter8x3.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded index and an
// optional tenure limit that revokes a held grant and pulses gnt_timeout in the idle cycle.
module rr_arbiter8x3 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       gnt_timeout
);

    localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic          state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_idx_q, gnt_idx_d;
    logic          gnt_vld_q, gnt_vld_d;
    logic          gnt_timeout_q, gnt_timeout_d;

    logic          sel_found;
    logic [2:0]    sel_idx;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        logic [2:0] idx;
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        idx       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hcnt_d        = hcnt_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        gnt_vld_d     = gnt_vld_q;
        gnt_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d   = ST_GRANT;
                    gnt_d     = 8'b1 << sel_idx;
                    gnt_idx_d = sel_idx;
                    gnt_vld_d = 1'b1;
                    hcnt_d    = HW'(1);
                end
            end
            default: begin
                // Release takes precedence over timeout when both apply on the same edge.
                if (!req[gnt_idx_q] || ((MAX_HOLD != 0) && (hcnt_q == HOLD_LIM))) begin
                    state_d       = ST_IDLE;
                    gnt_d         = 8'h00;
                    gnt_idx_d     = 3'd0;
                    gnt_vld_d     = 1'b0;
                    ptr_d         = gnt_idx_q + 3'd1;
                    gnt_timeout_d = req[gnt_idx_q];
                end else if (hcnt_q != {HW{1'b1}}) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 3'd0;
            hcnt_q        <= '0;
            gnt_q         <= 8'h00;
            gnt_idx_q     <= 3'd0;
            gnt_vld_q     <= 1'b0;
            gnt_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hcnt_q        <= hcnt_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            gnt_vld_q     <= gnt_vld_d;
            gnt_timeout_q <= gnt_timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign gnt_vld     = gnt_vld_q;
    assign gnt_timeout = gnt_timeout_q;

endmodule

// File: tb/tb_rr_arbiter8x3.sv
// Directed bench for rr_arbiter8x3: three instances (MAX_HOLD 16, 4, 0) share clock, reset and req.
module tb_rr_arbiter8x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_a, gnt_b, gnt_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;
    logic       to_a, to_b, to_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter8x3 dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .gnt_timeout(to_a)
    );

    rr_arbiter8x3 #(.MAX_HOLD(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .gnt_timeout(to_b)
    );

    rr_arbiter8x3 #(.MAX_HOLD(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_vld(vld_c), .gnt_timeout(to_c)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        rst_n = 1'b0;
        req   = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = 13'd0;
            n_cmp++;
            if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got %h required %h", i, {gnt_a, idx_a, vld_a, to_a}, exp);
            end
        end
        rst_n = 1'b1;
        step();
        exp = {8'h01, 3'd0, 1'b1, 1'b0};
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL reset_first_grant got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
    endtask

    task automatic test_single();
        logic [12:0] exp;
        do_reset();
        req = 8'b0000_0100;
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {8'h04, 3'd2, 1'b1, 1'b0};
            n_cmp++;
            if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
                n_err++;
                $display("FAIL single_hold[%0d] got %h required %h", i, {gnt_a, idx_a, vld_a, to_a}, exp);
            end
        end
        req = 8'h00;
        step();
        exp = 13'd0;
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL single_release got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
        req = 8'hFF;
        step();
        exp = {8'h08, 3'd3, 1'b1, 1'b0};
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL single_next_ptr got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
    endtask

    task automatic test_rotation_timeout();
        logic [12:0] exp;
        logic [2:0]  seq [5];
        seq = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1};
        do_reset();
        req = 8'b1010_1010;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                exp = {8'b1 << seq[g], seq[g], 1'b1, 1'b0};
                n_cmp++;
                if ({gnt_b, idx_b, vld_b, to_b} !== exp) begin
                    n_err++;
                    $display("FAIL rotate_grant[%0d.%0d] got %h required %h",
                             g, c, {gnt_b, idx_b, vld_b, to_b}, exp);
                end
            end
            step();
            exp = {8'h00, 3'd0, 1'b0, 1'b1};
            n_cmp++;
            if ({gnt_b, idx_b, vld_b, to_b} !== exp) begin
                n_err++;
                $display("FAIL rotate_timeout[%0d] got %h required %h", g, {gnt_b, idx_b, vld_b, to_b}, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [12:0] exp;
        logic [12:0] exps [5];
        logic [7:0]  reqs [5];
        reqs = '{8'h40, 8'h81, 8'h81, 8'h01, 8'h01};
        exps = '{{8'h40, 3'd6, 1'b1, 1'b0}, 13'd0, {8'h80, 3'd7, 1'b1, 1'b0},
                 13'd0, {8'h01, 3'd0, 1'b1, 1'b0}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = reqs[i];
            step();
            exp = exps[i];
            n_cmp++;
            if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
                n_err++;
                $display("FAIL wrap[%0d] got %h required %h", i, {gnt_a, idx_a, vld_a, to_a}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [12:0] exp;
        do_reset();
        req = 8'h20;
        step();
        req = 8'hFF;
        step();
        exp = {8'h20, 3'd5, 1'b1, 1'b0};
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL midrst_grant got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
        rst_n = 1'b0;
        step();
        exp = 13'd0;
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL midrst_abort got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
        rst_n = 1'b1;
        step();
        exp = {8'h01, 3'd0, 1'b1, 1'b0};
        n_cmp++;
        if ({gnt_a, idx_a, vld_a, to_a} !== exp) begin
            n_err++;
            $display("FAIL midrst_ptr0 got %h required %h", {gnt_a, idx_a, vld_a, to_a}, exp);
        end
    endtask

    task automatic test_last_cycle_and_nolimit();
        logic [12:0] exp;
        do_reset();
        req = 8'h01;
        for (int c = 0; c < 4; c++) begin
            step();
            exp = {8'h01, 3'd0, 1'b1, 1'b0};
            n_cmp++;
            if ({gnt_b, idx_b, vld_b, to_b} !== exp) begin
                n_err++;
                $display("FAIL lastcyc_grant[%0d] got %h required %h", c, {gnt_b, idx_b, vld_b, to_b}, exp);
            end
        end
        req = 8'h00;
        for (int c = 0; c < 2; c++) begin
            step();
            exp = 13'd0;
            n_cmp++;
            if ({gnt_b, idx_b, vld_b, to_b} !== exp) begin
                n_err++;
                $display("FAIL lastcyc_release[%0d] got %h required %h", c, {gnt_b, idx_b, vld_b, to_b}, exp);
            end
        end
        do_reset();
        req = 8'h01;
        for (int c = 0; c < 100; c++) begin
            step();
            exp = {8'h01, 3'd0, 1'b1, 1'b0};
            n_cmp++;
            if ({gnt_c, idx_c, vld_c, to_c} !== exp) begin
                n_err++;
                $display("FAIL nolimit[%0d] got %h required %h", c, {gnt_c, idx_c, vld_c, to_c}, exp);
            end
        end
        req = 8'h00;
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_rotation_timeout();
        test_wrap();
        test_reset_mid_grant();
        test_last_cycle_and_nolimit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8x3.md
Name: rr_arbiter8x3

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Issues a one-hot grant and its 3-bit encoded index, the same 8-to-3 encoding produced by the team's encoder8x3.
- Holds a grant until the owner drops its request, or until an optional tenure limit expires.
- Sits in front of any shared datapath driven by an 8-line request bus.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the limit (tenure ends only on request drop).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  8  request lines; bit i = requester i; level-sensitive.
- gnt  output  8  one-hot grant; all-zero when no grant.
- gnt_idx  output  3  binary index of the granted requester (encoder8x3 encoding of gnt); 0 when idle.
- gnt_vld  output  1  high when gnt is non-zero.
- gnt_timeout  output  1  one-cycle pulse in the cycle after a grant is revoked by MAX_HOLD expiry.

Behaviour:
- All outputs are registered.
- Internal state: FSM {IDLE, GRANT}, 3-bit priority pointer ptr, hold counter hcnt.
- hcnt width is clog2(MAX_HOLD+1), minimum 1 bit. It saturates and never wraps.

Reset:
- Any clk edge with rst_n=0 sets state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, gnt_timeout=0, ptr=0, hcnt=0.
- Reset during GRANT aborts the grant at that edge. The first post-reset arbitration uses ptr=0.

IDLE:
- At an edge with req != 0, select the first set bit scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1.
- Next-state values: state=GRANT, gnt=one-hot(sel), gnt_idx=sel, gnt_vld=1, hcnt=1.
- Latency is one cycle: a req sampled at edge k gives gnt valid after edge k.
- req=0 keeps IDLE with outputs at zero.
- gnt_timeout is cleared at every IDLE edge unless it is being set by the rule below.

GRANT:
- Only req[gnt_idx] is observed. Changes on other req lines are ignored until the tenure ends.
- Release: at an edge with req[gnt_idx]=0, set gnt=0, gnt_idx=0, gnt_vld=0, ptr=(old gnt_idx+1) mod 8, state=IDLE.
- Timeout: at an edge with MAX_HOLD!=0, hcnt==MAX_HOLD and req[gnt_idx]=1, apply the same actions as release and also set gnt_timeout=1 for exactly one cycle.
- If release and timeout coincide (request drops on the last allowed cycle), it counts as a release: gnt_timeout stays 0.
- Otherwise hcnt increments, saturating.
- gnt is therefore high for at most MAX_HOLD consecutive cycles.

Turnaround:
- Every tenure end is followed by exactly one cycle with gnt_vld=0 (the IDLE cycle). Back-to-back grants are never issued.
- A revoked requester that keeps req high becomes lowest priority through ptr. If it is the only requester, it is re-granted after the one idle cycle.

Invariants:
- gnt is zero or one-hot.
- gnt_vld == |gnt.
- gnt_idx matches the position of the set bit in gnt.
- gnt_timeout=1 implies gnt_vld=0 in the same cycle.

Test Plan:
1. Reset hold: rst_n=0 for 3 cycles with req=8'hFF -> gnt=8'h00, gnt_idx=0, gnt_vld=0, gnt_timeout=0 on every cycle; rst_n=1 -> the edge after deassertion gives gnt=8'h01, gnt_idx=0.
2. Single requester: req=8'b0000_0100 for 5 cycles, then 0 -> gnt=8'b0000_0100 with gnt_idx=2 starting one cycle after req, for 5 cycles; gnt=0 one cycle after req drops; the following grant with req=8'hFF goes to idx 3 (ptr=3).
3. Rotation with timeout, MAX_HOLD=4: req=8'b1010_1010 held from reset -> grant sequence idx 1,3,5,7,1. Each grant lasts 4 cycles, is separated by one idle cycle, and has a gnt_timeout pulse in that idle cycle.
4. Wrap-around: grant idx 6, then release with req=8'b1000_0001 -> next grant idx 7, then after release idx 0; no timeout pulses.
5. Reset mid-grant: during a grant to idx 5 with req=8'hFF, rst_n=0 for one cycle -> gnt=0 at that edge; after rst_n=1, the next grant goes to idx 0 (ptr reset), not idx 6.
6. Release on last cycle plus no-limit mode: with MAX_HOLD=4, drop req on the 4th grant cycle -> gnt_timeout stays 0. With MAX_HOLD=0, req=8'h01 held for 100 cycles -> gnt=8'h01 continuously, gnt_timeout never asserts.
